// File: rtl/mpu_regfile_write_arb_if.sv
// mpu_regfile_write_arb_if: request, register-file write and status signals of the write arbiter
//  master : LD/WB requesters and register-file observer (drives *_in, sees *_out)
//  slave  : the arbiter (drives gnt, reg_* strobe/data, busy/owner and error pulses)
interface mpu_regfile_write_arb_if #(
  parameter int MATRIX_REG_BITS = 3,
  parameter int FPBITS          = 31,
  parameter int MBITS           = 3,
  parameter int NBITS           = 3
);
  logic                     ld_en_in, wb_en_in;
  logic                     ld_gnt_out, wb_gnt_out;
  logic [MATRIX_REG_BITS:0] ld_addr_in, wb_addr_in;
  logic [FPBITS:0]          ld_element_in, wb_element_in;
  logic [MBITS:0]           ld_i_in, wb_i_in, ld_m_in, wb_m_in;
  logic [NBITS:0]           ld_j_in, wb_j_in, ld_n_in, wb_n_in;
  logic                     reg_load_en_out;
  logic [MATRIX_REG_BITS:0] reg_load_addr_out;
  logic [FPBITS:0]          reg_load_element_out;
  logic [MBITS:0]           reg_i_load_loc_out, reg_m_load_size_out;
  logic [NBITS:0]           reg_j_load_loc_out, reg_n_load_size_out;
  logic                     busy_out, owner_out, err_size_out, err_tmo_out;
  modport master (
    output ld_en_in, wb_en_in, ld_addr_in, wb_addr_in, ld_element_in, wb_element_in,
           ld_i_in, wb_i_in, ld_m_in, wb_m_in, ld_j_in, wb_j_in, ld_n_in, wb_n_in,
    input  ld_gnt_out, wb_gnt_out, reg_load_en_out, reg_load_addr_out, reg_load_element_out,
           reg_i_load_loc_out, reg_m_load_size_out, reg_j_load_loc_out, reg_n_load_size_out,
           busy_out, owner_out, err_size_out, err_tmo_out
  );
  modport slave (
    input  ld_en_in, wb_en_in, ld_addr_in, wb_addr_in, ld_element_in, wb_element_in,
           ld_i_in, wb_i_in, ld_m_in, wb_m_in, ld_j_in, wb_j_in, ld_n_in, wb_n_in,
    output ld_gnt_out, wb_gnt_out, reg_load_en_out, reg_load_addr_out, reg_load_element_out,
           reg_i_load_loc_out, reg_m_load_size_out, reg_j_load_loc_out, reg_n_load_size_out,
           busy_out, owner_out, err_size_out, err_tmo_out
  );
endinterface

// File: rtl/mpu_regfile_write_arb.sv
// mpu_regfile_write_arb: locks the matrix register-file write port to LD or WB for a whole matrix
//  clk, rst_n : clock and asynchronous active-low reset
//  bus.ld_* / bus.wb_* : element requests with combinational grants
//  bus.reg_*  : registered write strobe and element to the register file (1-cycle latency)
//  bus.busy_out/owner_out : lock held and its owner (0 = LD, 1 = WB)
//  bus.err_size_out/err_tmo_out : pulses for a dropped bad element / a timed-out lock
module mpu_regfile_write_arb #(
  parameter bit RR_EN           = 1'b1,
  parameter int IDLE_TMO        = 64,
  parameter int MATRIX_REG_BITS = 3,
  parameter int FPBITS          = 31,
  parameter int MBITS           = 3,
  parameter int NBITS           = 3,
  parameter int M               = 8,
  parameter int N               = 8
) (
  input logic clk,
  input logic rst_n,
  mpu_regfile_write_arb_if.slave bus
);
  localparam int MW = MBITS + 1;
  localparam int NW = NBITS + 1;
  localparam int CW = $clog2(IDLE_TMO + 1);
  localparam logic [MW-1:0] M_MAX = MW'(M);
  localparam logic [NW-1:0] N_MAX = NW'(N);
  localparam logic [MW-1:0] M_ONE = MW'(1);
  localparam logic [NW-1:0] N_ONE = NW'(1);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [CW-1:0] TMO_LAST = CW'(IDLE_TMO - 1);
  typedef enum logic [1:0] {ARB_IDLE, ARB_LD, ARB_WB} arb_state_e;
  arb_state_e               state;
  logic                     last_owner;
  logic [CW-1:0]            idle_cnt;
  logic                     win_wb, ld_gnt, wb_gnt, acc, sel_bad, sel_last;
  logic [MATRIX_REG_BITS:0] sel_addr;
  logic [FPBITS:0]          sel_element;
  logic [MW-1:0]            sel_i, sel_m;
  logic [NW-1:0]            sel_j, sel_n;
  // Grants are gated by rst_n so every output reads 0 while reset is held.
  always_comb begin
    win_wb      = bus.wb_en_in & (!bus.ld_en_in | (RR_EN & !last_owner));
    ld_gnt      = rst_n & ((state == ARB_IDLE) ? (bus.ld_en_in & !win_wb) : ((state == ARB_LD) & bus.ld_en_in));
    wb_gnt      = rst_n & ((state == ARB_IDLE) ? win_wb : ((state == ARB_WB) & bus.wb_en_in));
    acc         = ld_gnt | wb_gnt;
    sel_addr    = wb_gnt ? bus.wb_addr_in    : bus.ld_addr_in;
    sel_element = wb_gnt ? bus.wb_element_in : bus.ld_element_in;
    sel_i       = wb_gnt ? bus.wb_i_in       : bus.ld_i_in;
    sel_j       = wb_gnt ? bus.wb_j_in       : bus.ld_j_in;
    sel_m       = wb_gnt ? bus.wb_m_in       : bus.ld_m_in;
    sel_n       = wb_gnt ? bus.wb_n_in       : bus.ld_n_in;
    sel_bad     = (sel_m == '0) || (sel_n == '0) || (sel_m > M_MAX) || (sel_n > N_MAX);
    sel_last    = (sel_i == sel_m - M_ONE) && (sel_j == sel_n - N_ONE);
  end
  assign bus.ld_gnt_out = ld_gnt;
  assign bus.wb_gnt_out = wb_gnt;
  assign bus.busy_out   = state != ARB_IDLE;
  assign bus.owner_out  = state == ARB_WB;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                    <= ARB_IDLE;
      last_owner               <= 1'b1;
      idle_cnt                 <= '0;
      bus.reg_load_en_out      <= 1'b0;
      bus.reg_load_addr_out    <= '0;
      bus.reg_load_element_out <= '0;
      bus.reg_i_load_loc_out   <= '0;
      bus.reg_j_load_loc_out   <= '0;
      bus.reg_m_load_size_out  <= '0;
      bus.reg_n_load_size_out  <= '0;
      bus.err_size_out         <= 1'b0;
      bus.err_tmo_out          <= 1'b0;
    end else begin
      bus.reg_load_en_out <= acc & !sel_bad;
      bus.err_size_out    <= acc & sel_bad;
      bus.err_tmo_out     <= 1'b0;
      if (acc & !sel_bad) begin
        bus.reg_load_addr_out    <= sel_addr;
        bus.reg_load_element_out <= sel_element;
        bus.reg_i_load_loc_out   <= sel_i;
        bus.reg_j_load_loc_out   <= sel_j;
        bus.reg_m_load_size_out  <= sel_m;
        bus.reg_n_load_size_out  <= sel_n;
      end
      if (acc) begin
        last_owner <= wb_gnt;
        idle_cnt   <= '0;
        if (!sel_bad && sel_last) state <= ARB_IDLE;
        else if (!sel_bad && state == ARB_IDLE) state <= wb_gnt ? ARB_WB : ARB_LD;
      end else if (state != ARB_IDLE) begin
        if (idle_cnt == TMO_LAST) begin
          state           <= ARB_IDLE;
          idle_cnt        <= '0;
          bus.err_tmo_out <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + C_ONE;
        end
      end
    end
  end
endmodule

// File: tb/tb_mpu_regfile_write_arb.sv
// tb_mpu_regfile_write_arb: directed scenarios plus a randomized run against a behavioural model
module tb_mpu_regfile_write_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int vectors = 0;
  int errors = 0;
  always #5 clk = ~clk;
  mpu_regfile_write_arb_if ia ();
  mpu_regfile_write_arb_if ib ();
  mpu_regfile_write_arb #(.RR_EN(1'b1), .IDLE_TMO(64)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  mpu_regfile_write_arb #(.RR_EN(1'b0), .IDLE_TMO(64)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib));

  task automatic set_a(int p, bit en, logic [3:0] addr, logic [3:0] i, logic [3:0] j,
                       logic [3:0] m, logic [3:0] n, logic [31:0] el);
    if (p == 0) begin
      ia.ld_en_in = en; ia.ld_addr_in = addr; ia.ld_i_in = i; ia.ld_j_in = j;
      ia.ld_m_in = m; ia.ld_n_in = n; ia.ld_element_in = el;
    end else begin
      ia.wb_en_in = en; ia.wb_addr_in = addr; ia.wb_i_in = i; ia.wb_j_in = j;
      ia.wb_m_in = m; ia.wb_n_in = n; ia.wb_element_in = el;
    end
  endtask

  task automatic set_b(int p, bit en, logic [3:0] addr, logic [3:0] i, logic [3:0] j,
                       logic [3:0] m, logic [3:0] n, logic [31:0] el);
    if (p == 0) begin
      ib.ld_en_in = en; ib.ld_addr_in = addr; ib.ld_i_in = i; ib.ld_j_in = j;
      ib.ld_m_in = m; ib.ld_n_in = n; ib.ld_element_in = el;
    end else begin
      ib.wb_en_in = en; ib.wb_addr_in = addr; ib.wb_i_in = i; ib.wb_j_in = j;
      ib.wb_m_in = m; ib.wb_n_in = n; ib.wb_element_in = el;
    end
  endtask

  task automatic clear_inputs;
    for (int p = 0; p < 2; p++) begin
      set_a(p, 1'b0, '0, '0, '0, '0, '0, '0);
      set_b(p, 1'b0, '0, '0, '0, '0, '0, '0);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    for (int p = 0; p < 2; p++) begin
      set_a(p, 1'b1, 4'd3, 4'd0, 4'd0, 4'd2, 4'd2, 32'hFFFF_FFFF);
      set_b(p, 1'b1, 4'd3, 4'd0, 4'd0, 4'd2, 4'd2, 32'hFFFF_FFFF);
    end
    #1 rst_n = 1'b0;
    #2;
    vectors++;
    if ({ia.ld_gnt_out, ia.wb_gnt_out, ia.reg_load_en_out, ia.busy_out, ia.owner_out, ia.err_size_out, ia.err_tmo_out} !== 7'b0) begin
      errors++; $display("FAIL reset_ctl_a got %b exp 0", {ia.ld_gnt_out, ia.wb_gnt_out, ia.reg_load_en_out, ia.busy_out, ia.owner_out, ia.err_size_out, ia.err_tmo_out});
    end
    vectors++;
    if ({ia.reg_load_addr_out, ia.reg_load_element_out, ia.reg_i_load_loc_out, ia.reg_j_load_loc_out, ia.reg_m_load_size_out, ia.reg_n_load_size_out} !== 52'h0) begin
      errors++; $display("FAIL reset_data_a got %h exp 0", {ia.reg_load_addr_out, ia.reg_load_element_out, ia.reg_i_load_loc_out, ia.reg_j_load_loc_out, ia.reg_m_load_size_out, ia.reg_n_load_size_out});
    end
    vectors++;
    if ({ib.ld_gnt_out, ib.wb_gnt_out, ib.reg_load_en_out, ib.busy_out, ib.owner_out, ib.err_size_out, ib.err_tmo_out} !== 7'b0) begin
      errors++; $display("FAIL reset_ctl_b got %b exp 0", {ib.ld_gnt_out, ib.wb_gnt_out, ib.reg_load_en_out, ib.busy_out, ib.owner_out, ib.err_size_out, ib.err_tmo_out});
    end
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ld_only;
    for (int k = 0; k < 4; k++) begin
      set_a(0, 1'b1, 4'd5, 4'(k >> 1), 4'(k & 1), 4'd2, 4'd2, 32'hA000_0000 + k);
      @(negedge clk);
      vectors++;
      if ({ia.ld_gnt_out, ia.wb_gnt_out, ia.busy_out, ia.owner_out} !== {1'b1, 1'b0, k != 0, 1'b0}) begin
        errors++; $display("FAIL ld_only_gnt beat %0d got %b exp %b", k, {ia.ld_gnt_out, ia.wb_gnt_out, ia.busy_out, ia.owner_out}, {1'b1, 1'b0, k != 0, 1'b0});
      end
      tick();
      vectors++;
      if ({ia.reg_load_en_out, ia.reg_load_addr_out, ia.reg_i_load_loc_out, ia.reg_j_load_loc_out, ia.reg_m_load_size_out, ia.reg_n_load_size_out, ia.reg_load_element_out, ia.busy_out}
          !== {1'b1, 4'd5, 4'(k >> 1), 4'(k & 1), 4'd2, 4'd2, 32'hA000_0000 + k, k < 3}) begin
        errors++; $display("FAIL ld_only_write beat %0d got en=%b i=%0d j=%0d el=%h busy=%b", k, ia.reg_load_en_out, ia.reg_i_load_loc_out, ia.reg_j_load_loc_out, ia.reg_load_element_out, ia.busy_out);
      end
    end
    set_a(0, 1'b0, '0, '0, '0, '0, '0, '0);
    tick();
    vectors++;
    if ({ia.reg_load_en_out, ia.busy_out} !== 2'b00) begin
      errors++; $display("FAIL ld_only_after got %b exp 00", {ia.reg_load_en_out, ia.busy_out});
    end
  endtask

  task automatic test_round_robin;
    int bl = 0;
    int bw = 0;
    bit exp_ld;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      set_a(0, 1'b1, 4'd1, 4'((bl % 4) >> 1), 4'(bl & 1), 4'd2, 4'd2, 32'h1000_0000 + bl);
      set_a(1, 1'b1, 4'd2, 4'((bw % 4) >> 1), 4'(bw & 1), 4'd2, 4'd2, 32'h2000_0000 + bw);
      exp_ld = (c < 4) || (c >= 8);
      @(negedge clk);
      vectors++;
      if ({ia.ld_gnt_out, ia.wb_gnt_out, ia.busy_out, ia.owner_out} !== {exp_ld, !exp_ld, (c % 4) != 0, (c >= 5) && (c <= 7)}) begin
        errors++; $display("FAIL rr_gnt cycle %0d got %b exp %b", c, {ia.ld_gnt_out, ia.wb_gnt_out, ia.busy_out, ia.owner_out}, {exp_ld, !exp_ld, (c % 4) != 0, (c >= 5) && (c <= 7)});
      end
      tick();
      vectors++;
      if ({ia.reg_load_en_out, ia.reg_load_element_out} !== {1'b1, exp_ld ? 32'h1000_0000 + bl : 32'h2000_0000 + bw}) begin
        errors++; $display("FAIL rr_write cycle %0d got en=%b el=%h", c, ia.reg_load_en_out, ia.reg_load_element_out);
      end
      if (exp_ld) bl++; else bw++;
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_fixed_priority;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      set_b(0, 1'b1, 4'd1, 4'((c % 4) >> 1), 4'(c & 1), 4'd2, 4'd2, 32'h3000_0000 + c);
      set_b(1, 1'b1, 4'd2, 4'd0, 4'd0, 4'd2, 4'd2, 32'h4000_0000);
      @(negedge clk);
      vectors++;
      if ({ib.ld_gnt_out, ib.wb_gnt_out, ib.busy_out} !== {1'b1, 1'b0, (c % 4) != 0}) begin
        errors++; $display("FAIL fixed_gnt cycle %0d got %b exp %b", c, {ib.ld_gnt_out, ib.wb_gnt_out, ib.busy_out}, {1'b1, 1'b0, (c % 4) != 0});
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_timeout;
    int pulses = 0;
    set_a(0, 1'b1, 4'd6, 4'd0, 4'd0, 4'd3, 4'd3, 32'h5000_0000);
    @(negedge clk);
    vectors++;
    if ({ia.ld_gnt_out, ia.wb_gnt_out} !== 2'b10) begin
      errors++; $display("FAIL tmo_first got %b exp 10", {ia.ld_gnt_out, ia.wb_gnt_out});
    end
    tick();
    set_a(0, 1'b1, 4'd6, 4'd0, 4'd1, 4'd3, 4'd3, 32'h5000_0001);
    set_a(1, 1'b1, 4'd7, 4'd0, 4'd0, 4'd2, 4'd2, 32'h6000_0000);
    @(negedge clk);
    vectors++;
    if ({ia.ld_gnt_out, ia.wb_gnt_out, ia.busy_out} !== 3'b101) begin
      errors++; $display("FAIL tmo_second got %b exp 101", {ia.ld_gnt_out, ia.wb_gnt_out, ia.busy_out});
    end
    tick();
    set_a(0, 1'b0, '0, '0, '0, '0, '0, '0);
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      pulses += int'(ia.err_tmo_out);
      vectors++;
      if ({ia.wb_gnt_out, ia.busy_out, ia.owner_out, ia.err_tmo_out} !== 4'b0100) begin
        errors++; $display("FAIL tmo_hold idle %0d got %b exp 0100", c, {ia.wb_gnt_out, ia.busy_out, ia.owner_out, ia.err_tmo_out});
      end
      tick();
    end
    @(negedge clk);
    pulses += int'(ia.err_tmo_out);
    vectors++;
    if ({ia.busy_out, ia.wb_gnt_out, ia.err_tmo_out} !== 3'b011) begin
      errors++; $display("FAIL tmo_release got %b exp 011", {ia.busy_out, ia.wb_gnt_out, ia.err_tmo_out});
    end
    tick();
    pulses += int'(ia.err_tmo_out);
    vectors++;
    if (pulses !== 1) begin
      errors++; $display("FAIL tmo_pulses got %0d exp 1", pulses);
    end
    vectors++;
    if ({ia.reg_load_en_out, ia.reg_load_element_out, ia.busy_out, ia.owner_out} !== {1'b1, 32'h6000_0000, 2'b11}) begin
      errors++; $display("FAIL tmo_wb_write got en=%b el=%h busy=%b owner=%b", ia.reg_load_en_out, ia.reg_load_element_out, ia.busy_out, ia.owner_out);
    end
    for (int b = 1; b < 4; b++) begin
      set_a(1, 1'b1, 4'd7, 4'(b >> 1), 4'(b & 1), 4'd2, 4'd2, 32'h6000_0000 + b);
      tick();
    end
    clear_inputs();
    tick();
    vectors++;
    if (ia.busy_out !== 1'b0) begin
      errors++; $display("FAIL tmo_wb_done got busy=%b exp 0", ia.busy_out);
    end
  endtask

  task automatic test_bad_size;
    for (int k = 0; k < 2; k++) begin
      set_a(1, 1'b1, 4'd2, 4'd0, 4'd0, k == 0 ? 4'd0 : 4'd2, k == 0 ? 4'd2 : 4'd9, 32'h7000_0000);
      @(negedge clk);
      vectors++;
      if ({ia.ld_gnt_out, ia.wb_gnt_out} !== 2'b01) begin
        errors++; $display("FAIL bad_gnt case %0d got %b exp 01", k, {ia.ld_gnt_out, ia.wb_gnt_out});
      end
      tick();
      vectors++;
      if ({ia.reg_load_en_out, ia.err_size_out, ia.busy_out} !== 3'b010) begin
        errors++; $display("FAIL bad_drop case %0d got %b exp 010", k, {ia.reg_load_en_out, ia.err_size_out, ia.busy_out});
      end
    end
    clear_inputs();
    tick();
    vectors++;
    if ({ia.reg_load_en_out, ia.err_size_out} !== 2'b00) begin
      errors++; $display("FAIL bad_pulse_end got %b exp 00", {ia.reg_load_en_out, ia.err_size_out});
    end
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 3; k++) begin
      set_a(0, 1'b1, 4'd4, 4'd0, 4'(k), 4'd4, 4'd4, 32'h8000_0000 + k);
      tick();
    end
    set_a(0, 1'b1, 4'd4, 4'd0, 4'd3, 4'd4, 4'd4, 32'h8000_0003);
    set_a(1, 1'b1, 4'd2, 4'd0, 4'd0, 4'd4, 4'd4, 32'h9000_0000);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({ia.ld_gnt_out, ia.wb_gnt_out, ia.reg_load_en_out, ia.busy_out, ia.owner_out, ia.err_size_out, ia.err_tmo_out} !== 7'b0) begin
      errors++; $display("FAIL rst_mid_ctl got %b exp 0", {ia.ld_gnt_out, ia.wb_gnt_out, ia.reg_load_en_out, ia.busy_out, ia.owner_out, ia.err_size_out, ia.err_tmo_out});
    end
    vectors++;
    if ({ia.reg_load_addr_out, ia.reg_load_element_out, ia.reg_i_load_loc_out, ia.reg_j_load_loc_out} !== 44'h0) begin
      errors++; $display("FAIL rst_mid_data got %h exp 0", {ia.reg_load_addr_out, ia.reg_load_element_out, ia.reg_i_load_loc_out, ia.reg_j_load_loc_out});
    end
    set_a(0, 1'b1, 4'd4, 4'd0, 4'd0, 4'd1, 4'd1, 32'h8000_0010);
    set_a(1, 1'b1, 4'd2, 4'd0, 4'd0, 4'd1, 4'd1, 32'h9000_0010);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if ({ia.ld_gnt_out, ia.wb_gnt_out} !== 2'b10) begin
      errors++; $display("FAIL rst_mid_tie got %b exp 10", {ia.ld_gnt_out, ia.wb_gnt_out});
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_random;
    int rm[2], rn[2], beat[2];
    bit cor[2], ren[2];
    logic [3:0] raddr[2];
    logic [31:0] rel[2];
    int own = -1, lastw = 1, idle = 0, win, dm, di, dj;
    bit bad, lst, e_reg, e_err, e_tmo;
    logic [51:0] exp_data;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      rm[p] = $urandom_range(1, 3); rn[p] = $urandom_range(1, 3); beat[p] = 0;
      raddr[p] = 4'($urandom); rel[p] = $urandom; cor[p] = 1'b0;
    end
    for (int c = 0; c < 500; c++) begin
      for (int p = 0; p < 2; p++) begin
        ren[p] = $urandom_range(0, 4) != 0;
        set_a(p, ren[p], raddr[p], 4'(beat[p] / rn[p]), 4'(beat[p] % rn[p]), cor[p] ? 4'd0 : 4'(rm[p]), 4'(rn[p]), rel[p]);
      end
      @(negedge clk);
      win = -1;
      if (own < 0) begin
        if (ren[0] && ren[1]) win = 1 - lastw;
        else if (ren[0]) win = 0;
        else if (ren[1]) win = 1;
      end else if (ren[own]) win = own;
      vectors++;
      if ({ia.ld_gnt_out, ia.wb_gnt_out, ia.busy_out, ia.owner_out} !== {win == 0, win == 1, own >= 0, own == 1}) begin
        errors++; $display("FAIL rand_gnt cycle %0d got %b exp %b", c, {ia.ld_gnt_out, ia.wb_gnt_out, ia.busy_out, ia.owner_out}, {win == 0, win == 1, own >= 0, own == 1});
      end
      e_reg = 1'b0; e_err = 1'b0; e_tmo = 1'b0; exp_data = '0;
      if (win >= 0) begin
        dm = cor[win] ? 0 : rm[win];
        di = beat[win] / rn[win];
        dj = beat[win] % rn[win];
        bad = (dm == 0) || (dm > 8) || (rn[win] > 8);
        lst = (di == dm - 1) && (dj == rn[win] - 1);
        e_reg = !bad; e_err = bad;
        exp_data = {raddr[win], rel[win], 4'(di), 4'(dj), 4'(dm), 4'(rn[win])};
        lastw = win; idle = 0;
        if (!bad) begin
          if (lst) own = -1;
          else if (own < 0) own = win;
        end
      end else if (own >= 0) begin
        idle++;
        if (idle == 64) begin own = -1; idle = 0; e_tmo = 1'b1; end
      end
      tick();
      vectors++;
      if ({ia.reg_load_en_out, ia.err_size_out, ia.err_tmo_out} !== {e_reg, e_err, e_tmo}) begin
        errors++; $display("FAIL rand_strobe cycle %0d got %b exp %b", c, {ia.reg_load_en_out, ia.err_size_out, ia.err_tmo_out}, {e_reg, e_err, e_tmo});
      end
      if (e_reg) begin
        vectors++;
        if ({ia.reg_load_addr_out, ia.reg_load_element_out, ia.reg_i_load_loc_out, ia.reg_j_load_loc_out, ia.reg_m_load_size_out, ia.reg_n_load_size_out} !== exp_data) begin
          errors++; $display("FAIL rand_data cycle %0d got %h exp %h", c, {ia.reg_load_addr_out, ia.reg_load_element_out, ia.reg_i_load_loc_out, ia.reg_j_load_loc_out, ia.reg_m_load_size_out, ia.reg_n_load_size_out}, exp_data);
        end
      end
      if (win >= 0) begin
        beat[win]++;
        if (beat[win] == rm[win] * rn[win]) begin
          beat[win] = 0; rm[win] = $urandom_range(1, 3); rn[win] = $urandom_range(1, 3); raddr[win] = 4'($urandom);
        end
        cor[win] = $urandom_range(0, 11) == 0;
        rel[win] = $urandom;
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_ld_only();
    test_round_robin();
    test_fixed_priority();
    test_timeout();
    test_bad_size();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired after %0d vectors", vectors);
    $fatal(1);
  end
endmodule
